// File: rtl/sblk_psum_drain.sv
// -----------------------------------------------------------------------------
// sblk_psum_drain
//
// Read-out sequencer for the superblock partial-sum buffers. A start command
// names a range of psum words (base_addr, n_words). For each word the block
// drives psum_rd_addr and waits out the buffer read latency. It then captures
// the full N_COLUMN-wide read word into a holding register. Finally it
// serialises the word one column slice per beat onto a valid/ready stream.
//
// Ports
//   clk_l         clock (single domain)
//   rst_n         asynchronous active-low reset; aborts any command in flight
//   start         command pulse, only honoured while idle
//   base_addr     first psum address of the range
//   n_words       number of words to drain (0 = complete immediately,
//                 values above 2^WID_PSUMADDR are limited to the whole buffer)
//   busy          high from the cycle after a command is accepted until done
//   done          one-cycle completion pulse
//   psum_rd_addr  psum buffer read address (held between word fetches)
//   psum_rd_data  psum read word, column c at [2*WID_PSUM*c +: 2*WID_PSUM]
//   out_data      serialised column slice
//   out_vld       out_data valid
//   out_rdy       downstream accept
//   out_last      marks the final beat of the command
//
// Every output is driven straight from a flop.
// -----------------------------------------------------------------------------
module sblk_psum_drain #(
  parameter int N_COLUMN     = 4,
  parameter int WID_PSUM     = 32,
  parameter int WID_PSUMADDR = 9,
  parameter int RD_LAT       = 2
) (
  input  logic                             clk_l,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic [WID_PSUMADDR-1:0]          base_addr,
  input  logic [WID_PSUMADDR:0]            n_words,
  output logic                             busy,
  output logic                             done,
  output logic [WID_PSUMADDR-1:0]          psum_rd_addr,
  input  logic [2*WID_PSUM*N_COLUMN-1:0]   psum_rd_data,
  output logic [2*WID_PSUM-1:0]            out_data,
  output logic                             out_vld,
  input  logic                             out_rdy,
  output logic                             out_last
);

  localparam int SLICE_W = 2 * WID_PSUM;
  localparam int WORD_W  = SLICE_W * N_COLUMN;
  localparam int COL_W   = (N_COLUMN > 1) ? $clog2(N_COLUMN) : 1;
  localparam int LAT_W   = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  localparam logic [COL_W-1:0]      COL_LAST  = COL_W'(N_COLUMN - 1);
  localparam logic [LAT_W-1:0]      LAT_LAST  = LAT_W'(RD_LAT - 1);
  localparam logic [WID_PSUMADDR:0] WORDS_ONE = (WID_PSUMADDR + 1)'(1);
  localparam logic [WID_PSUMADDR:0] MAX_WORDS = {1'b1, {WID_PSUMADDR{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_SEND,
    S_FIN
  } state_t;

  // Column slice idx of a full psum word.
  function automatic logic [SLICE_W-1:0] col_slice(input logic [WORD_W-1:0] word,
                                                   input logic [COL_W-1:0]  idx);
    col_slice = word[idx*SLICE_W +: SLICE_W];
  endfunction

  // A beat is the command's last when it is the final column of the final word.
  function automatic logic last_beat(input logic [COL_W-1:0]      col,
                                     input logic [WID_PSUMADDR:0] words_left);
    last_beat = (col == COL_LAST) && (words_left == WORDS_ONE);
  endfunction

  // Requests larger than the buffer drain the whole buffer exactly once.
  function automatic logic [WID_PSUMADDR:0] clamp_words(input logic [WID_PSUMADDR:0] n);
    clamp_words = (n > MAX_WORDS) ? MAX_WORDS : n;
  endfunction

  state_t                  state_q, state_d;
  logic [WID_PSUMADDR-1:0] psum_rd_addr_q, psum_rd_addr_d;
  logic [WID_PSUMADDR:0]   words_left_q, words_left_d;
  logic [LAT_W-1:0]        lat_cnt_q, lat_cnt_d;
  logic [COL_W-1:0]        col_cnt_q, col_cnt_d;
  logic [COL_W-1:0]        col_nxt;
  logic [WORD_W-1:0]       hold_q, hold_d;
  logic [SLICE_W-1:0]      out_data_q, out_data_d;
  logic                    out_vld_q, out_vld_d;
  logic                    out_last_q, out_last_d;
  logic                    done_q, done_d;
  logic                    busy_q, busy_d;

  always_comb begin
    state_d        = state_q;
    psum_rd_addr_d = psum_rd_addr_q;
    words_left_d   = words_left_q;
    lat_cnt_d      = lat_cnt_q;
    col_cnt_d      = col_cnt_q;
    hold_d         = hold_q;
    out_data_d     = out_data_q;
    out_vld_d      = out_vld_q;
    out_last_d     = out_last_q;
    col_nxt        = col_cnt_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        // done_q marks the completion cycle of the previous command; busy is
        // still high then, so a start in that cycle is not taken either.
        if (start && !done_q) begin
          if (n_words == '0) begin
            state_d = S_FIN;
          end else begin
            state_d        = S_ISSUE;
            psum_rd_addr_d = base_addr;
            words_left_d   = clamp_words(n_words);
          end
        end
      end

      S_ISSUE: begin
        // psum_rd_addr already presents the word address during this cycle.
        state_d   = S_WAIT;
        lat_cnt_d = '0;
      end

      S_WAIT: begin
        if (lat_cnt_q == LAT_LAST) begin
          state_d    = S_SEND;
          hold_d     = psum_rd_data;
          col_cnt_d  = '0;
          out_vld_d  = 1'b1;
          out_data_d = col_slice(psum_rd_data, '0);
          out_last_d = last_beat('0, words_left_q);
        end else begin
          lat_cnt_d = lat_cnt_q + 1'b1;
        end
      end

      S_SEND: begin
        // Nothing moves until the current beat is accepted, which keeps
        // out_data/out_last stable under back-pressure.
        if (out_vld_q && out_rdy) begin
          if (col_cnt_q == COL_LAST) begin
            out_vld_d    = 1'b0;
            out_last_d   = 1'b0;
            words_left_d = words_left_q - 1'b1;
            if (words_left_q != WORDS_ONE) begin
              state_d        = S_ISSUE;
              psum_rd_addr_d = psum_rd_addr_q + 1'b1;
            end else begin
              state_d = S_FIN;
            end
          end else begin
            col_cnt_d  = col_nxt;
            out_data_d = col_slice(hold_q, col_nxt);
            out_last_d = last_beat(col_nxt, words_left_q);
          end
        end
      end

      S_FIN: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // The completion pulse is registered out of FIN, so it appears in the
    // first idle cycle; busy stays up through it and falls with it.
    done_d = (state_q == S_FIN);
    busy_d = (state_d != S_IDLE) || done_d;
  end

  always_ff @(posedge clk_l or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      psum_rd_addr_q <= '0;
      words_left_q   <= '0;
      lat_cnt_q      <= '0;
      col_cnt_q      <= '0;
      out_data_q     <= '0;
      out_vld_q      <= 1'b0;
      out_last_q     <= 1'b0;
      done_q         <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      psum_rd_addr_q <= psum_rd_addr_d;
      words_left_q   <= words_left_d;
      lat_cnt_q      <= lat_cnt_d;
      col_cnt_q      <= col_cnt_d;
      out_data_q     <= out_data_d;
      out_vld_q      <= out_vld_d;
      out_last_q     <= out_last_d;
      done_q         <= done_d;
      busy_q         <= busy_d;
    end
  end

  // The holding register is pure datapath and is always loaded before use.
  always_ff @(posedge clk_l) begin
    hold_q <= hold_d;
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign psum_rd_addr = psum_rd_addr_q;
  assign out_data     = out_data_q;
  assign out_vld      = out_vld_q;
  assign out_last     = out_last_q;

endmodule

// File: tb/tb_sblk_psum_drain.sv
module tb_sblk_psum_drain;

  localparam int N_COLUMN     = 4;
  localparam int WID_PSUM     = 32;
  localparam int WID_PSUMADDR = 9;
  localparam int RD_LAT       = 2;
  localparam int SLICE_W      = 2 * WID_PSUM;
  localparam int WORD_W       = SLICE_W * N_COLUMN;
  localparam int DEPTH        = 1 << WID_PSUMADDR;
  localparam int BUDGET       = 20000;

  logic                    clk_l = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    start = 1'b0;
  logic [WID_PSUMADDR-1:0] base_addr = '0;
  logic [WID_PSUMADDR:0]   n_words = '0;
  logic                    busy;
  logic                    done;
  logic [WID_PSUMADDR-1:0] psum_rd_addr;
  logic [WORD_W-1:0]       psum_rd_data;
  logic [SLICE_W-1:0]      out_data;
  logic                    out_vld;
  logic                    out_rdy = 1'b0;
  logic                    out_last;

  sblk_psum_drain #(
    .N_COLUMN    (N_COLUMN),
    .WID_PSUM    (WID_PSUM),
    .WID_PSUMADDR(WID_PSUMADDR),
    .RD_LAT      (RD_LAT)
  ) dut (
    .clk_l       (clk_l),
    .rst_n       (rst_n),
    .start       (start),
    .base_addr   (base_addr),
    .n_words     (n_words),
    .busy        (busy),
    .done        (done),
    .psum_rd_addr(psum_rd_addr),
    .psum_rd_data(psum_rd_data),
    .out_data    (out_data),
    .out_vld     (out_vld),
    .out_rdy     (out_rdy),
    .out_last    (out_last)
  );

  always #5 clk_l = ~clk_l;

  // Psum buffer model: read data appears RD_LAT edges after the address.
  logic [WORD_W-1:0] mem [DEPTH];
  logic [WORD_W-1:0] rd_pipe [RD_LAT];
  always @(posedge clk_l) begin
    rd_pipe[0] <= mem[psum_rd_addr];
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign psum_rd_data = rd_pipe[RD_LAT-1];

  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model state
  logic [SLICE_W:0]        exp_beats [$];   // {last, data}
  logic [WID_PSUMADDR-1:0] exp_addr  [$];
  logic [WID_PSUMADDR-1:0] addr_log  [$];
  logic [WID_PSUMADDR-1:0] last_addr = '0;
  int pending       = 0;
  int cyc           = 0;
  int acc_cyc       = 0;
  int first_vld_cyc = -1;
  int last_xfer_cyc = 0;
  int done_cyc      = 0;
  int n_beats       = 0;
  int n_last        = 0;
  int n_done        = 0;
  bit rdy_rand      = 1'b0;

  // Expected beats and addresses for an accepted command.
  task automatic model_push(input logic [WID_PSUMADDR-1:0] b, input logic [WID_PSUMADDR:0] n);
    int nw;
    logic [WID_PSUMADDR-1:0] a;
    nw = (n > (WID_PSUMADDR+1)'(DEPTH)) ? DEPTH : int'(n);
    for (int w = 0; w < nw; w++) begin
      a = b + WID_PSUMADDR'(w);
      if (!(w == 0 && a == last_addr)) exp_addr.push_back(a);
      for (int c = 0; c < N_COLUMN; c++)
        exp_beats.push_back({(w == nw - 1) && (c == N_COLUMN - 1), mem[a][c*SLICE_W +: SLICE_W]});
    end
  endtask

  initial forever begin
    @(posedge clk_l);
    cyc++;
  end

  initial forever begin
    @(posedge clk_l);
    #2;
    out_rdy = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Compare process: every negedge while out of reset.
  initial begin : monitor
    logic               prev_vld, prev_rdy, prev_last, prev_done;
    logic [SLICE_W-1:0] prev_data;
    logic [SLICE_W:0]   e;
    prev_vld = 0; prev_rdy = 0; prev_last = 0; prev_done = 0; prev_data = '0;
    forever begin
      @(negedge clk_l);
      if (!rst_n) begin
        prev_vld = 0; prev_done = 0;
      end else begin
        if (prev_vld && !prev_rdy) begin
          check("hold_vld", 64'(out_vld), 64'd1);
          check("hold_data", out_data, prev_data);
          check("hold_last", 64'(out_last), 64'(prev_last));
        end
        check("busy", 64'(busy), 64'(pending > 0));
        if (out_vld && first_vld_cyc < 0) first_vld_cyc = cyc;
        if (out_vld && out_rdy) begin
          n_beats++;
          last_xfer_cyc = cyc;
          if (out_last) n_last++;
          if (exp_beats.size() == 0) begin
            check("extra_beat", 64'd1, 64'd0);
          end else begin
            e = exp_beats.pop_front();
            check("beat_data", out_data, e[SLICE_W-1:0]);
            check("beat_last", 64'(out_last), 64'(e[SLICE_W]));
          end
        end
        if (done) begin
          check("done_single", 64'(prev_done), 64'd0);
          check("done_drained", 64'(exp_beats.size()), 64'd0);
          check("done_expected", 64'(pending > 0), 64'd1);
          if (pending > 0) pending--;
          done_cyc = cyc;
          n_done++;
        end
        if (psum_rd_addr != last_addr) begin
          addr_log.push_back(psum_rd_addr);
          last_addr = psum_rd_addr;
        end
        prev_vld = out_vld; prev_rdy = out_rdy; prev_data = out_data;
        prev_last = out_last; prev_done = done;
      end
    end
  end

  task automatic issue_cmd(input logic [WID_PSUMADDR-1:0] b, input logic [WID_PSUMADDR:0] n);
    @(posedge clk_l);
    #2;
    first_vld_cyc = -1;
    start = 1'b1; base_addr = b; n_words = n;
    @(posedge clk_l);
    #2;
    model_push(b, n);
    pending++;
    acc_cyc = cyc;
    start = 1'b0;
  endtask

  task automatic pulse_start(input logic [WID_PSUMADDR-1:0] b, input logic [WID_PSUMADDR:0] n);
    @(posedge clk_l);
    #2;
    start = 1'b1; base_addr = b; n_words = n;
    @(posedge clk_l);
    #2;
    start = 1'b0;
  endtask

  task automatic wait_done();
    int k;
    for (k = 0; k < BUDGET; k++) begin
      @(negedge clk_l);
      #1;
      if (pending == 0) break;
    end
    check("done_timeout", 64'(k < BUDGET), 64'd1);
  endtask

  task automatic check_addrs();
    check("addr_count", 64'(addr_log.size()), 64'(exp_addr.size()));
    for (int i = 0; i < exp_addr.size() && i < addr_log.size(); i++)
      check("addr_seq", 64'(addr_log[i]), 64'(exp_addr[i]));
    addr_log.delete();
    exp_addr.delete();
  endtask

  initial begin
    int beats0, done0, k;
    logic [WID_PSUMADDR-1:0] a0;
    logic [WID_PSUMADDR-1:0] t2 [3];

    for (int a = 0; a < DEPTH; a++)
      for (int j = 0; j < WORD_W / 32; j++) mem[a][j*32 +: 32] = $urandom;
    for (int c = 0; c < N_COLUMN; c++) mem[5][c*SLICE_W +: SLICE_W] = SLICE_W'(c + 1);
    for (int i = 0; i < RD_LAT; i++) rd_pipe[i] = '0;

    // Reset state
    #12;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_vld", 64'(out_vld), 64'd0);
    check("rst_last", 64'(out_last), 64'd0);
    check("rst_addr", 64'(psum_rd_addr), 64'd0);
    check("rst_data", out_data, 64'd0);
    @(posedge clk_l);
    #2 rst_n = 1'b1;

    // 1: single word, known data, exact latency
    rdy_rand = 0;
    beats0 = n_beats;
    issue_cmd(9'd5, 10'd1);
    check("t1_model_c0", exp_beats[0], {1'b0, 64'd1});
    check("t1_model_c3", exp_beats[3], {1'b1, 64'd4});
    wait_done();
    check("t1_first_vld", 64'(first_vld_cyc), 64'(acc_cyc + 1 + RD_LAT));
    check("t1_done_cyc", 64'(done_cyc), 64'(last_xfer_cyc + 2));
    check("t1_beats", 64'(n_beats - beats0), 64'd4);
    check_addrs();

    // 2: address wrap
    beats0 = n_beats; n_last = 0;
    issue_cmd(9'd510, 10'd3);
    wait_done();
    for (int i = 0; i < 3; i++) t2[i] = (i < addr_log.size()) ? addr_log[i] : 9'h100;
    check("t2_addr0", 64'(t2[0]), 64'd510);
    check("t2_addr1", 64'(t2[1]), 64'd511);
    check("t2_addr2", 64'(t2[2]), 64'd0);
    check("t2_beats", 64'(n_beats - beats0), 64'd12);
    check("t2_lasts", 64'(n_last), 64'd1);
    check_addrs();

    // 3: back-pressure
    rdy_rand = 1;
    issue_cmd(9'd77, 10'd3);
    wait_done();
    check_addrs();

    // 4: zero-length command
    a0 = psum_rd_addr;
    issue_cmd(9'd300, 10'd0);
    wait_done();
    check("t4_done_cyc", 64'(done_cyc), 64'(acc_cyc + 1));
    check("t4_no_vld", 64'(first_vld_cyc), 64'hFFFF_FFFF_FFFF_FFFF);
    check("t4_addr_kept", 64'(psum_rd_addr), 64'(a0));
    check_addrs();

    // 6: start while busy is ignored
    beats0 = n_beats; done0 = n_done;
    issue_cmd(9'd40, 10'd2);
    pulse_start(9'd200, 10'd5);
    repeat (6) @(posedge clk_l);
    pulse_start(9'd201, 10'd0);
    wait_done();
    repeat (4) @(negedge clk_l);
    check("t6_beats", 64'(n_beats - beats0), 64'd8);
    check("t6_dones", 64'(n_done - done0), 64'd1);
    check_addrs();

    // 5: reset in the middle of SEND
    rdy_rand = 0;
    issue_cmd(9'd100, 10'd3);
    for (k = 0; k < 50 && !out_vld; k++) @(negedge clk_l);
    check("t5_reached_send", 64'(out_vld), 64'd1);
    @(posedge clk_l);
    #2 rst_n = 1'b0;
    #1;
    check("t5_vld", 64'(out_vld), 64'd0);
    check("t5_busy", 64'(busy), 64'd0);
    check("t5_done", 64'(done), 64'd0);
    check("t5_addr", 64'(psum_rd_addr), 64'd0);
    exp_beats.delete(); exp_addr.delete(); addr_log.delete();
    pending = 0; last_addr = '0;
    repeat (3) @(posedge clk_l);
    #2 rst_n = 1'b1;
    done0 = n_done;
    repeat (10) @(negedge clk_l);
    check("t5_no_done", 64'(n_done - done0), 64'd0);
    issue_cmd(9'd5, 10'd1);
    wait_done();
    check_addrs();

    // Randomised commands
    rdy_rand = 1;
    for (int r = 0; r < 25; r++) begin
      issue_cmd(9'($urandom_range(0, DEPTH - 1)), 10'($urandom_range(0, 5)));
      wait_done();
      check_addrs();
    end

    // Whole buffer, and an oversize request limited to the whole buffer
    rdy_rand = 0;
    beats0 = n_beats;
    issue_cmd(9'd3, 10'd512);
    wait_done();
    check("full_beats", 64'(n_beats - beats0), 64'(DEPTH * N_COLUMN));
    check_addrs();
    beats0 = n_beats;
    issue_cmd(9'd450, 10'd1023);
    wait_done();
    check("clamp_beats", 64'(n_beats - beats0), 64'(DEPTH * N_COLUMN));
    check_addrs();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
